// File: rtl/instr_fetch_queue_pkg.sv
// rtl/instr_fetch_queue_pkg.sv - opcode constants, fetch FSM states, queue entry type and opcode legality helper
package instr_fetch_queue_pkg;

    localparam int OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b000001;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000110;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b000111;

    // Two live states; the remaining 2-bit codes are spare and recover to ST_RUN.
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01
    } fetch_state_e;

    // One queue entry: instruction word tagged with the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // True for the opcodes the control unit decodes.
    function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_RTYPE, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_ADDI: is_legal_op = 1'b1;
            default:                                         is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_queue_sync_fifo.sv
// rtl/instr_fetch_queue_sync_fifo.sv - in-order entry buffer with flush, simultaneous push/pop legal at any fill
module instr_fetch_queue_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a push at full is accepted when paired with a pop.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

    // Pointer and occupancy next state; flush discards everything including a same-cycle push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - credit-based instruction fetch queue with redirect/drain; OPCODE_CHECK_EN holds illegal heads
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    output logic [31:0]         imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic                issue_valid,
    input  logic                issue_ready,
    output logic [31:0]         issue_instr,
    output logic [31:0]         issue_pc,
    output logic [OPCODE_W-1:0] opcode,
    output logic                illegal
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic          active_q;

    logic [CW-1:0] fifo_count;
    logic          fifo_valid;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic [SW-1:0] credit_used;
    logic          req_fire;
    logic          rsp_fire;
    logic          push;
    logic          pop;
    logic          head_legal;
    logic          head_blocked;
    logic [31:0]   redirect_pc_aligned;
    logic [31:0]   rsp_pc;
    logic          unused_redirect_lsbs;

    assign redirect_pc_aligned  = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Every queued word plus every in-flight fetch holds a slot, so the queue can never overflow.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, out_q};
    assign imem_req_valid = active_q && (state_q == ST_RUN) && (credit_used < SW'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses with nothing in flight are leftovers from before a reset and are ignored.
    assign rsp_fire = imem_rsp_valid && (out_q != '0);

    // In RUN the in-flight fetches are consecutive words ending just below pc_q, so the oldest one's PC follows.
    assign rsp_pc         = pc_q - 32'({out_q, 2'b00});
    assign push_entry.pc    = rsp_pc;
    assign push_entry.instr = imem_rsp_data;

    assign push = (state_q == ST_RUN) && rsp_fire && !redirect_valid;
    assign pop  = issue_valid && issue_ready && !redirect_valid;

    assign head_legal = is_legal_op(head.instr[31:26]);
`ifdef OPCODE_CHECK_EN
    assign head_blocked = !head_legal;
`else
    assign head_blocked = 1'b0;
`endif

    assign issue_valid = fifo_valid && !head_blocked;
    assign issue_instr = fifo_valid ? head.instr : '0;
    assign issue_pc    = fifo_valid ? head.pc : '0;
    assign opcode      = issue_valid ? head.instr[31:26] : '0;
    assign illegal     = fifo_valid && !head_legal;

    instr_fetch_queue_sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    // Fetch PC, in-flight count and RUN/DRAIN next state; a redirect overrides the PC step of a same-cycle accept.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        out_d   = out_q;
        if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
        if (req_fire && !rsp_fire) begin
            out_d = out_q + CW'(1);
        end else if (!req_fire && rsp_fire) begin
            out_d = out_q - CW'(1);
        end
        if (redirect_valid) begin
            pc_d    = redirect_pc_aligned;
            state_d = (out_d == '0) ? ST_RUN : ST_DRAIN;
        end else begin
            case (state_q)
                ST_RUN:   state_d = ST_RUN;
                ST_DRAIN: state_d = (out_d == '0) ? ST_RUN : ST_DRAIN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // Control registers; active_q keeps the request port quiet until the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            out_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            out_q    <= out_d;
            active_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - randomized bench against a queue-based model of the fetch queue
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          NCYC     = 4000;
`ifdef OPCODE_CHECK_EN
    localparam bit HOLD_ILLEGAL = 1'b1;
`else
    localparam bit HOLD_ILLEGAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [31:0] issue_instr;
    logic [31:0] issue_pc;
    logic [5:0]  opcode;
    logic        illegal;

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_instr    (issue_instr),
        .issue_pc       (issue_pc),
        .opcode         (opcode),
        .illegal        (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } mem_t;

    ent_t        mq[$];
    logic [31:0] m_inflight[$];
    mem_t        mem_pend[$];
    logic [31:0] m_pc;
    bit          m_drain;
    bit          m_active;
    bit          m_rv;
    bit          m_iv;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit op_ok(input logic [5:0] op);
        return op inside {6'b000000, 6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111};
    endfunction

    function automatic logic [31:0] gen_word();
        logic [5:0]  op;
        int unsigned u;
        if ($urandom_range(0, 7) == 0) begin
            op = 6'($urandom);
        end else begin
            u  = $urandom_range(0, 5);
            op = 6'((u < 2) ? u : u + 2);
        end
        return {op, 26'($urandom)};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_inflight.delete();
        m_pc     = RESET_PC;
        m_drain  = 1'b0;
        m_active = 1'b0;
    endtask

    task automatic compare_outputs();
        bit          hv;
        bit          ill;
        logic [31:0] h_instr;
        logic [31:0] h_pc;
        hv      = mq.size() > 0;
        h_instr = hv ? mq[0].instr : 32'h0;
        h_pc    = hv ? mq[0].pc : 32'h0;
        ill     = hv && !op_ok(h_instr[31:26]);
        m_iv    = hv && !(HOLD_ILLEGAL && ill);
        m_rv    = m_active && !m_drain && ((mq.size() + m_inflight.size()) < DEPTH);
        chk_eq("req_valid", imem_req_valid, m_rv);
        chk_eq("req_addr", imem_req_addr, m_pc);
        chk_eq("issue_valid", issue_valid, m_iv);
        chk_eq("issue_instr", issue_instr, h_instr);
        chk_eq("issue_pc", issue_pc, h_pc);
        chk_eq("opcode", opcode, m_iv ? h_instr[31:26] : 6'h0);
        chk_eq("illegal", illegal, ill);
    endtask

    task automatic drive_inputs();
        rst_n          = !((cyc < 3) || ($urandom_range(0, 399) == 0));
        imem_req_ready = ($urandom_range(0, 3) != 0);
        issue_ready    = ((cyc % 150) < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 29) == 0);
        redirect_pc    = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        if (mem_pend.size() > 0 && mem_pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_pend[0].data;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic model_step();
        bit          acc;
        bit          rsp;
        bit          pop;
        logic [31:0] rpc;
        acc = m_rv && imem_req_ready;
        rpc = 32'h0;
        if (imem_rsp_valid) begin
            void'(mem_pend.pop_front());
        end
        if (acc) begin
            mem_pend.push_back('{data: gen_word(), due: cyc + 1 + $urandom_range(0, 3)});
        end
        if (!rst_n) begin
            model_reset();
        end else begin
            rsp = imem_rsp_valid && (m_inflight.size() > 0);
            pop = m_iv && issue_ready;
            if (rsp) begin
                rpc = m_inflight.pop_front();
            end
            if (acc) begin
                m_inflight.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (redirect_valid) begin
                mq.delete();
                m_pc    = {redirect_pc[31:2], 2'b00};
                m_drain = m_inflight.size() > 0;
            end else begin
                if (pop) begin
                    void'(mq.pop_front());
                end
                if (rsp && !m_drain) begin
                    mq.push_back('{pc: rpc, instr: imem_rsp_data});
                end
                if (m_drain && m_inflight.size() == 0) begin
                    m_drain = 1'b0;
                end
            end
            m_active = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < NCYC; i++) begin
            @(negedge clk);
            compare_outputs();
            drive_inputs();
            @(posedge clk);
            model_step();
            cyc++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
